pixel_frame_receiver: RTL and testbench
=======================================

Name: pixel_frame_receiver

Overview:
Receiving end of the sensor's parallel pixel output bus. Accepts beats of OUTPUT_BUS_WIDTH pixels, tracks row and column position, and writes each beat into a frame memory through a registered write port. Frame completion is flagged on the falling edge of the sensor's pixel_frame_finished, and the block checks that exactly one full frame of beats arrived. It sits between SENSOR_TOP's data_out and the frame buffer or host readout logic.

Parameters:
PIXEL_ARRAY_WIDTH, 8, pixels per row; must be a multiple of OUTPUT_BUS_WIDTH
PIXEL_ARRAY_HEIGHT, 8, rows per frame
PIXEL_BITS, 8, bits per pixel
OUTPUT_BUS_WIDTH, 4, pixels per beat

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
in_valid  in  1  one beat present on in_data this cycle
in_data  in  [OUTPUT_BUS_WIDTH-1:0][PIXEL_BITS-1:0]  beat pixels; index 0 is the leftmost pixel
in_frame_finished  in  1  sensor frame-finished level; a falling edge ends readout
mem_we  out  1  frame-memory write strobe
mem_addr  out  $clog2(BEATS_PER_FRAME)  beat address, row*BEATS_PER_ROW+col
mem_wdata  out  [OUTPUT_BUS_WIDTH-1:0][PIXEL_BITS-1:0]  registered beat data
row_done  out  1  one-cycle pulse after the last beat of a row is written
frame_done  out  1  one-cycle pulse on frame end
frame_error  out  1  sticky error flag for the current/last frame
busy  out  1  high in RECEIVE and FULL states

Behaviour:
- Derived constants: BEATS_PER_ROW = PIXEL_ARRAY_WIDTH/OUTPUT_BUS_WIDTH; BEATS_PER_FRAME = BEATS_PER_ROW*PIXEL_ARRAY_HEIGHT.
- Reset values: all outputs 0. State = IDLE. Counters = 0. fin_q (registered in_frame_finished) = 0.
- Falling-edge detection: fall = fin_q & ~in_frame_finished, evaluated combinationally each cycle. fin_q is updated every cycle.
- FSM states and transitions:
  - IDLE: on in_valid, accept the beat, clear frame_error, go to RECEIVE. A fall seen in IDLE is ignored.
  - RECEIVE: each in_valid writes one beat and increments col. When col wraps at BEATS_PER_ROW-1, col returns to 0 and row increments. On acceptance of beat BEATS_PER_FRAME-1, go to FULL.
  - RECEIVE, on fall with the frame short: set frame_error, go to DONE.
  - FULL: in_valid beats are discarded (no mem_we) and set frame_error. On fall, go to DONE.
  - DONE: one cycle. Assert frame_done, clear counters, go to IDLE.
- Write latency: mem_we, mem_addr and mem_wdata are registered, appearing the cycle after in_valid.
- row_done: asserted in the same cycle as the mem_we of the row's last beat.
- frame_done: asserted exactly one cycle after the fall cycle.
- Simultaneous last beat and fall in the same cycle: the beat is accepted first, so the frame counts as complete, frame_error stays 0, and the next state is DONE.
- in_valid during DONE: the beat is discarded and frame_error is set.
- frame_error holds until the first beat of the next frame.
- Reset mid-frame: the partial frame is discarded. No frame_done is issued, and the next beat writes address 0.
- busy = (state==RECEIVE)|(state==FULL).

Optional Feature:
PIXEL_RX_CHECKSUM_EN
- Defined: adds output frame_checksum, width PIXEL_BITS+$clog2(PIXEL_ARRAY_WIDTH*PIXEL_ARRAY_HEIGHT), unsigned.
  - It is the zero-extended sum of every accepted pixel; discarded beats are excluded.
  - Cleared on the first beat of a frame.
  - Stable and valid from the frame_done cycle until the next frame starts.
  - Reset value 0.
- Undefined: the port and adder are absent; all other behaviour is unchanged.

Decomposition:
- Add to PixelSensorConfig:
  - BEATS_PER_ROW and BEATS_PER_FRAME constants
  - typedef beat_t, a packed [OUTPUT_BUS_WIDTH-1:0][PIXEL_BITS-1:0]
  - enum rx_state_t {IDLE, RECEIVE, FULL, DONE}
- One sub-module, rx_beat_counter:
  - Row and column counters with wrap.
  - Outputs: beat address, last_in_row, last_in_frame.
  - Has clear and increment inputs.

Test Plan (defaults; 2 beats/row, 16 beats/frame):
- Full frame: 16 beats with in_data pixels = beat index, then drop in_frame_finished.
  - Expect 16 mem_we at addresses 0..15 with matching data and 8 row_done pulses.
  - Expect one frame_done exactly 1 cycle after the fall, with frame_error=0.
- Short frame: 10 beats, then fall.
  - Expect addresses 0..9 written and row_done ×5.
  - Expect frame_done with frame_error=1; frame_error clears on the first beat of the next frame.
- Overflow: 18 beats, then fall.
  - Expect only addresses 0..15 written and frame_error=1 from the 17th beat; frame_done still pulses.
- Reset after 5 beats, then a full frame.
  - Expect no frame_done for the partial frame; the new frame writes from address 0 and finishes with frame_error=0.
- Last beat and fall in the same cycle.
  - Expect the beat written to address 15, frame_done the next cycle, frame_error=0.
- With PIXEL_RX_CHECKSUM_EN: full frame of all pixels = 3.
  - Expect frame_checksum=192 at frame_done.
  - A following frame of all 255 gives 16320.

Source files
------------

// File: rtl/pixel_frame_receiver_pkg.sv
// Shared constants, types and helpers for the sensor pixel-bus receiver.
// Default geometry: 8x8 pixels, 8 bits per pixel, 4 pixels per beat.
package pixel_frame_receiver_pkg;

  localparam int unsigned DEF_PIXEL_ARRAY_WIDTH  = 8;
  localparam int unsigned DEF_PIXEL_ARRAY_HEIGHT = 8;
  localparam int unsigned DEF_PIXEL_BITS         = 8;
  localparam int unsigned DEF_OUTPUT_BUS_WIDTH   = 4;

  localparam int unsigned BEATS_PER_ROW   = DEF_PIXEL_ARRAY_WIDTH / DEF_OUTPUT_BUS_WIDTH;
  localparam int unsigned BEATS_PER_FRAME = BEATS_PER_ROW * DEF_PIXEL_ARRAY_HEIGHT;

  typedef logic [DEF_OUTPUT_BUS_WIDTH-1:0][DEF_PIXEL_BITS-1:0] beat_t;

  typedef enum logic [1:0] {
    IDLE,
    RECEIVE,
    FULL,
    DONE
  } rx_state_t;

  // Counter/address width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/pixel_frame_receiver_rx_beat_counter.sv
// Row/column beat position tracker for the pixel receiver; produces the
// linear frame-memory beat address and end-of-row / end-of-frame flags.
module rx_beat_counter
  import pixel_frame_receiver_pkg::*;
#(
  parameter int ROW_BEATS = 2,
  parameter int ROWS      = 8,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              incr,
  output logic [ADDR_W-1:0] addr,
  output logic              last_in_row,
  output logic              last_in_frame
);

  localparam int COL_W = clog2_min1(ROW_BEATS);
  localparam int ROW_W = clog2_min1(ROWS);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  assign last_in_row   = (col == COL_W'(ROW_BEATS - 1));
  assign last_in_frame = last_in_row && (row == ROW_W'(ROWS - 1));
  assign addr          = ADDR_W'(row) * ADDR_W'(ROW_BEATS) + ADDR_W'(col);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col <= '0;
      row <= '0;
    end else if (incr) begin
      if (last_in_row) begin
        col <= '0;
        row <= (row == ROW_W'(ROWS - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_frame_receiver.sv
// Receiver for the sensor parallel pixel bus: writes beats into frame memory,
// flags frame completion and frame length errors. Optional PIXEL_RX_CHECKSUM_EN.
module pixel_frame_receiver
  import pixel_frame_receiver_pkg::*;
#(
  parameter int unsigned PIXEL_ARRAY_WIDTH  = DEF_PIXEL_ARRAY_WIDTH,
  parameter int unsigned PIXEL_ARRAY_HEIGHT = DEF_PIXEL_ARRAY_HEIGHT,
  parameter int unsigned PIXEL_BITS         = DEF_PIXEL_BITS,
  parameter int unsigned OUTPUT_BUS_WIDTH   = DEF_OUTPUT_BUS_WIDTH,
  localparam int ROW_BEATS   = int'(PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH),
  localparam int FRAME_BEATS = ROW_BEATS * int'(PIXEL_ARRAY_HEIGHT),
  localparam int ADDR_W      = clog2_min1(FRAME_BEATS)
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         in_valid,
  input  logic [OUTPUT_BUS_WIDTH-1:0][PIXEL_BITS-1:0]  in_data,
  input  logic                                         in_frame_finished,
  output logic                                         mem_we,
  output logic [ADDR_W-1:0]                            mem_addr,
  output logic [OUTPUT_BUS_WIDTH-1:0][PIXEL_BITS-1:0]  mem_wdata,
  output logic                                         row_done,
  output logic                                         frame_done,
  output logic                                         frame_error,
  output logic                                         busy
`ifdef PIXEL_RX_CHECKSUM_EN
  ,
  output logic [PIXEL_BITS+$clog2(PIXEL_ARRAY_WIDTH*PIXEL_ARRAY_HEIGHT)-1:0] frame_checksum
`endif
);

  rx_state_t         state;
  logic              fin_q;
  logic              fall;
  logic              accept;
  logic [ADDR_W-1:0] beat_addr;
  logic              last_in_row;
  logic              last_in_frame;

  assign fall   = fin_q & ~in_frame_finished;
  assign accept = in_valid & ((state == IDLE) | (state == RECEIVE));
  assign busy   = (state == RECEIVE) | (state == FULL);

  rx_beat_counter #(
    .ROW_BEATS (ROW_BEATS),
    .ROWS      (int'(PIXEL_ARRAY_HEIGHT)),
    .ADDR_W    (ADDR_W)
  ) u_beat_counter (
    .clk           (clk),
    .reset         (reset),
    .clear         (state == DONE),
    .incr          (accept),
    .addr          (beat_addr),
    .last_in_row   (last_in_row),
    .last_in_frame (last_in_frame)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      fin_q       <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      row_done    <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      fin_q      <= in_frame_finished;
      mem_we     <= accept;
      row_done   <= accept & last_in_row;
      frame_done <= 1'b0;
      if (accept) begin
        mem_addr  <= beat_addr;
        mem_wdata <= in_data;
      end

      case (state)
        IDLE: begin
          if (in_valid) begin
            frame_error <= 1'b0;
            state       <= last_in_frame ? FULL : RECEIVE;
          end
        end
        RECEIVE: begin
          // A final beat coinciding with the fall still completes the frame.
          if (accept && last_in_frame) begin
            state      <= fall ? DONE : FULL;
            frame_done <= fall;
          end else if (fall) begin
            frame_error <= 1'b1;
            frame_done  <= 1'b1;
            state       <= DONE;
          end
        end
        FULL: begin
          if (in_valid) frame_error <= 1'b1;
          if (fall) begin
            frame_done <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (in_valid) frame_error <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PIXEL_RX_CHECKSUM_EN
  localparam int CSUM_W = int'(PIXEL_BITS) + $clog2(PIXEL_ARRAY_WIDTH * PIXEL_ARRAY_HEIGHT);

  logic [CSUM_W-1:0] beat_sum;
  logic [CSUM_W-1:0] csum;

  always_comb begin
    beat_sum = '0;
    for (int unsigned i = 0; i < OUTPUT_BUS_WIDTH; i++) begin
      beat_sum = beat_sum + CSUM_W'(in_data[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      csum <= '0;
    end else if (accept) begin
      csum <= (state == IDLE) ? beat_sum : csum + beat_sum;
    end
  end

  assign frame_checksum = csum;
`endif

endmodule

// File: tb/tb_pixel_frame_receiver.sv
// Randomized bench for pixel_frame_receiver against a frame-level model:
// expected writes queue, frame length error rule and pixel sum per frame.
module tb_pixel_frame_receiver;
  import pixel_frame_receiver_pkg::*;

  localparam int W   = 8;
  localparam int H   = 8;
  localparam int PB  = 8;
  localparam int OBW = 4;
  localparam int BPR = W / OBW;
  localparam int BPF = BPR * H;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  beat_t      in_data;
  logic       fin;
  logic       mem_we;
  logic [3:0] mem_addr;
  beat_t      mem_wdata;
  logic       row_done;
  logic       frame_done;
  logic       frame_error;
  logic       busy;
`ifdef PIXEL_RX_CHECKSUM_EN
  logic [13:0] frame_checksum;
`endif

  always #5 clk = ~clk;

  pixel_frame_receiver #(
    .PIXEL_ARRAY_WIDTH  (W),
    .PIXEL_ARRAY_HEIGHT (H),
    .PIXEL_BITS         (PB),
    .OUTPUT_BUS_WIDTH   (OBW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_frame_finished (fin),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .row_done          (row_done),
    .frame_done        (frame_done),
    .frame_error       (frame_error),
    .busy              (busy)
`ifdef PIXEL_RX_CHECKSUM_EN
    ,
    .frame_checksum    (frame_checksum)
`endif
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, want, $time);
    end
  endtask

  typedef struct {
    int    addr;
    beat_t data;
    bit    row_end;
  } wr_t;

  wr_t exp_q[$];
  int  done_seen = 0;
  int  acc;
  int  sum;

  // Observed writes must match the expected write queue in order.
  always @(negedge clk) begin
    wr_t e;
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", mem_we, 0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", mem_wdata, e.data);
        check("row_done", row_done, e.row_end);
      end
    end else if (row_done) begin
      check("row_done_stray", row_done, 0);
    end
    if (frame_done) done_seen++;
  end

  function automatic beat_t make_beat(input int b, input int pat);
    beat_t d;
    for (int i = 0; i < OBW; i++) begin
      case (pat)
        0:       d[i] = 8'($urandom_range(0, 255));
        1:       d[i] = 8'(b);
        2:       d[i] = 8'd3;
        default: d[i] = 8'd255;
      endcase
    end
    return d;
  endfunction

  // Frame model: only the first BPF beats of a frame land in memory.
  task automatic model_accept(input beat_t d);
    wr_t e;
    if (acc < BPF) begin
      e.addr    = acc;
      e.data    = d;
      e.row_end = ((acc % BPR) == BPR - 1);
      exp_q.push_back(e);
      for (int i = 0; i < OBW; i++) sum += int'(d[i]);
    end
    acc++;
  endtask

  task automatic send_frame(input int n, input int pat, input bit same_fall, input bit stray);
    beat_t d;
    int    done0;
    int    exp_err;
    acc     = 0;
    sum     = 0;
    done0   = done_seen;
    exp_err = (n != BPF) ? 1 : 0;
    for (int b = 0; b < n; b++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      d        = make_beat(b, pat);
      in_valid = 1'b1;
      in_data  = d;
      fin      = 1'b1;
      if (same_fall && b == n - 1) fin = 1'b0;
      model_accept(d);
      if ((b == 0 || b == BPF) && !(same_fall && b == n - 1)) begin
        @(negedge clk);
        in_valid = 1'b0;
        check("frame_error_mid", frame_error, (b == 0) ? 0 : 1);
        check("busy_mid", busy, 1);
      end
    end
    if (!same_fall) begin
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      fin      = 1'b0;
    end
    @(negedge clk);
    in_valid = stray;
    in_data  = make_beat(0, 0);
    check("frame_done_pulse", frame_done, 1);
    check("frame_error_end", frame_error, exp_err);
    check("busy_done", busy, 0);
`ifdef PIXEL_RX_CHECKSUM_EN
    check("checksum", frame_checksum, sum);
`endif
    @(negedge clk);
    in_valid = 1'b0;
    check("frame_done_width", frame_done, 0);
    check("frame_done_count", done_seen - done0, 1);
    check("frame_error_after", frame_error, exp_err | int'(stray));
    check("writes_drained", exp_q.size(), 0);
`ifdef PIXEL_RX_CHECKSUM_EN
    check("checksum_hold", frame_checksum, sum);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int done0;
    reset    = 1'b1;
    in_valid = 1'b0;
    fin      = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_row_done", row_done, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_error", frame_error, 0);
    check("rst_busy", busy, 0);
`ifdef PIXEL_RX_CHECKSUM_EN
    check("rst_checksum", frame_checksum, 0);
`endif
    reset = 1'b0;

    // A fall while idle must not end a frame.
    done0 = done_seen;
    @(negedge clk); fin = 1'b1;
    @(negedge clk); fin = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_fall_ignored", done_seen - done0, 0);
    check("idle_busy", busy, 0);

    send_frame(BPF, 1, 1'b0, 1'b0);
    send_frame(10, 0, 1'b0, 1'b0);
    send_frame(BPF + 2, 0, 1'b0, 1'b0);

    // Reset in the middle of a frame discards it silently.
    acc   = 0;
    sum   = 0;
    done0 = done_seen;
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = make_beat(b, 0);
      fin      = 1'b1;
      model_accept(in_data);
    end
    @(negedge clk);
    in_valid = 1'b0;
    fin      = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_mem_we", mem_we, 0);
    check("midrst_error", frame_error, 0);
    repeat (3) @(negedge clk);
    check("midrst_no_done", done_seen - done0, 0);
    check("midrst_drained", exp_q.size(), 0);
    send_frame(BPF, 0, 1'b0, 1'b0);

    send_frame(BPF, 0, 1'b1, 1'b0);
    send_frame(BPF, 2, 1'b0, 1'b0);
    send_frame(BPF, 3, 1'b0, 1'b0);
    send_frame(BPF, 0, 1'b0, 1'b1);

    for (int k = 0; k < 20; k++) begin
      int n;
      n = $urandom_range(1, BPF + 4);
      if ($urandom_range(0, 2) == 0) n = BPF;
      send_frame(n, $urandom_range(0, 3),
                 (n == BPF) && ($urandom_range(0, 1) == 1),
                 $urandom_range(0, 3) == 0);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
